// File: rtl/seq_divider_if.sv
// Start/done handshake bundle between the arithmetic controller and the divider.
// The master modport is the controller side; the divider takes the slave side.
interface seq_divider_if #(
    parameter int unsigned WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start,
        output dividend,
        output divisor,
        input  busy,
        input  done,
        input  quotient,
        input  remainder,
        input  div_by_zero
    );

    modport slave (
        input  start,
        input  dividend,
        input  divisor,
        output busy,
        output done,
        output quotient,
        output remainder,
        output div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per clock from a shift-and-subtract datapath.
// Results are published only on entry to DONE and held until the next result or reset.
module seq_divider #(
    parameter int unsigned WIDTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    seq_divider_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH:0]   prem;
    logic [WIDTH-1:0] qsr;
    logic [WIDTH-1:0] dvs;
    logic [CW-1:0]    cnt;

    logic             busy_r;
    logic             done_r;
    logic             dz_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] rem_r;

    logic [WIDTH:0]   prem_sh;
    logic [WIDTH+1:0] trial;
    logic [WIDTH:0]   prem_nx;
    logic [WIDTH-1:0] qsr_nx;

    // One iteration: shift {prem, qsr} left, trial-subtract with an extra borrow bit.
    always_comb begin
        prem_sh = {prem[WIDTH-1:0], qsr[WIDTH-1]};
        trial   = {1'b0, prem_sh} - {2'b00, dvs};
        prem_nx = prem_sh;
        qsr_nx  = {qsr[WIDTH-2:0], 1'b0};
        if (!trial[WIDTH+1]) begin
            prem_nx = trial[WIDTH:0];
            qsr_nx  = {qsr[WIDTH-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            prem   <= '0;
            qsr    <= '0;
            dvs    <= '0;
            cnt    <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            dz_r   <= 1'b0;
            quo_r  <= '0;
            rem_r  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        if (bus.divisor != '0) begin
                            dvs    <= bus.divisor;
                            qsr    <= bus.dividend;
                            prem   <= '0;
                            cnt    <= CW'(WIDTH);
                            busy_r <= 1'b1;
                            dz_r   <= 1'b0;
                            state  <= CALC;
                        end else begin
                            quo_r  <= '1;
                            rem_r  <= bus.dividend;
                            dz_r   <= 1'b1;
                            done_r <= 1'b1;
                            state  <= DONE;
                        end
                    end
                end
                CALC: begin
                    prem <= prem_nx;
                    qsr  <= qsr_nx;
                    cnt  <= cnt - CW'(1);
                    // Last iteration: publish the freshly computed bits directly.
                    if (cnt == CW'(1)) begin
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        quo_r  <= qsr_nx;
                        rem_r  <= prem_nx[WIDTH-1:0];
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.div_by_zero = dz_r;
    assign bus.quotient    = quo_r;
    assign bus.remainder   = rem_r;
endmodule
